// File: rtl/fb_swap_controller.sv
// Double-buffer sequencer: clears the back page, gates renderer writes into it,
// swaps pages on vblank and counts display frames repeated because the renderer ran late.
module fb_swap_controller #(
    parameter int                 FB_W        = 320,
    parameter int                 FB_H        = 240,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = {COLOR_W{1'b0}}
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               new_frame,
    input  logic               clear_en,
    input  logic [8:0]         render_x,
    input  logic [7:0]         render_y,
    input  logic [COLOR_W-1:0] render_color,
    input  logic               render_we,
    input  logic               render_done,
    output logic               render_start,
    output logic               render_ack,
    output logic [8:0]         fb_x,
    output logic [7:0]         fb_y,
    output logic [COLOR_W-1:0] fb_color,
    output logic               fb_we,
    output logic               write_page,
    output logic               disp_page,
    output logic [7:0]         drop_count
);

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_START     = 2'd1,
        ST_RENDER    = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } state_t;

    localparam logic [8:0] X_LAST = 9'(FB_W - 1);
    localparam logic [7:0] Y_LAST = 8'(FB_H - 1);

    state_t             state_r, state_s;
    logic [8:0]         cx_r, cx_s;
    logic [7:0]         cy_r, cy_s;
    logic [8:0]         fb_x_r, fb_x_s;
    logic [7:0]         fb_y_r, fb_y_s;
    logic [COLOR_W-1:0] fb_color_r, fb_color_s;
    logic               fb_we_r, fb_we_s;
    logic               disp_page_r, disp_page_s;
    logic [7:0]         drop_r, drop_s;
    logic               start_r, start_s;
    logic               ack_r, ack_s;
    logic               in_range_s;

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_CLEAR;
            cx_r        <= 9'd0;
            cy_r        <= 8'd0;
            fb_x_r      <= 9'd0;
            fb_y_r      <= 8'd0;
            fb_color_r  <= {COLOR_W{1'b0}};
            fb_we_r     <= 1'b0;
            disp_page_r <= 1'b0;
            drop_r      <= 8'd0;
            start_r     <= 1'b0;
            ack_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cx_r        <= cx_s;
            cy_r        <= cy_s;
            fb_x_r      <= fb_x_s;
            fb_y_r      <= fb_y_s;
            fb_color_r  <= fb_color_s;
            fb_we_r     <= fb_we_s;
            disp_page_r <= disp_page_s;
            drop_r      <= drop_s;
            start_r     <= start_s;
            ack_r       <= ack_s;
        end
    end

    // Next-state, clear scan, write gating, swap and drop counting
    always_comb begin
        state_s     = state_r;
        cx_s        = cx_r;
        cy_s        = cy_r;
        fb_x_s      = fb_x_r;
        fb_y_s      = fb_y_r;
        fb_color_s  = fb_color_r;
        fb_we_s     = 1'b0;
        disp_page_s = disp_page_r;
        ack_s       = 1'b0;
        in_range_s  = ({1'b0, render_x} < 10'(FB_W)) && ({1'b0, render_y} < 9'(FB_H));

        case (state_r)
            ST_CLEAR: begin
                // clear_en is only consulted at the top of the scan so a running clear completes
                if (!clear_en && (cx_r == 9'd0) && (cy_r == 8'd0)) begin
                    state_s = ST_START;
                end else begin
                    fb_we_s    = 1'b1;
                    fb_x_s     = cx_r;
                    fb_y_s     = cy_r;
                    fb_color_s = CLEAR_COLOR;
                    if (cx_r == X_LAST) begin
                        cx_s = 9'd0;
                        if (cy_r == Y_LAST) begin
                            cy_s    = 8'd0;
                            state_s = ST_START;
                        end else begin
                            cy_s = cy_r + 8'd1;
                        end
                    end else begin
                        cx_s = cx_r + 9'd1;
                    end
                end
            end
            ST_START: begin
                state_s = ST_RENDER;
            end
            ST_RENDER: begin
                fb_x_s     = render_x;
                fb_y_s     = render_y;
                fb_color_s = render_color;
                fb_we_s    = render_we && in_range_s;
                if (render_done) begin
                    state_s = ST_WAIT_SWAP;
                end else begin
                    state_s = ST_RENDER;
                end
            end
            ST_WAIT_SWAP: begin
                if (new_frame) begin
                    disp_page_s = ~disp_page_r;
                    ack_s       = 1'b1;
                    state_s     = ST_CLEAR;
                end else begin
                    state_s = ST_WAIT_SWAP;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                cx_s    = 9'd0;
                cy_s    = 8'd0;
            end
        endcase

        // render_start is high for exactly the single cycle spent in START
        start_s = (state_s == ST_START);

        if (new_frame && (state_r != ST_WAIT_SWAP) && (drop_r != 8'hFF)) begin
            drop_s = drop_r + 8'd1;
        end else begin
            drop_s = drop_r;
        end
    end

    assign fb_x         = fb_x_r;
    assign fb_y         = fb_y_r;
    assign fb_color     = fb_color_r;
    assign fb_we        = fb_we_r;
    assign disp_page    = disp_page_r;
    assign write_page   = ~disp_page_r;
    assign drop_count   = drop_r;
    assign render_start = start_r;
    assign render_ack   = ack_r;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed self-checking bench for fb_swap_controller on a 4x3 framebuffer.
module tb_fb_swap_controller;

    logic       Clk;
    logic       Reset;
    logic       new_frame;
    logic       clear_en;
    logic [8:0] render_x;
    logic [7:0] render_y;
    logic [7:0] render_color;
    logic       render_we;
    logic       render_done;
    logic       render_start;
    logic       render_ack;
    logic [8:0] fb_x;
    logic [7:0] fb_y;
    logic [7:0] fb_color;
    logic       fb_we;
    logic       write_page;
    logic       disp_page;
    logic [7:0] drop_count;

    int errors = 0;
    int checks = 0;

    fb_swap_controller #(
        .FB_W        (4),
        .FB_H        (3),
        .COLOR_W     (8),
        .CLEAR_COLOR (8'h00)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .new_frame    (new_frame),
        .clear_en     (clear_en),
        .render_x     (render_x),
        .render_y     (render_y),
        .render_color (render_color),
        .render_we    (render_we),
        .render_done  (render_done),
        .render_start (render_start),
        .render_ack   (render_ack),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_color     (fb_color),
        .fb_we        (fb_we),
        .write_page   (write_page),
        .disp_page    (disp_page),
        .drop_count   (drop_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Entered at the negedge where the DUT sits in CLEAR with counters at zero.
    // A renderer write held throughout must never reach the framebuffer.
    task automatic test_clear(input logic exp_wp);
        logic exp_st;
        render_we = 1'b1; render_x = 9'd1; render_y = 8'd1; render_color = 8'h77;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            exp_st = (k == 11) ? 1'b1 : 1'b0;
            checks++;
            if (fb_we !== 1'b1 || fb_x !== 9'(k % 4) || fb_y !== 8'(k / 4) || fb_color !== 8'h00) begin
                errors++;
                $display("FAIL clear_write k=%0d got we=%b x=%0d y=%0d c=%h exp we=1 x=%0d y=%0d c=00",
                         k, fb_we, fb_x, fb_y, fb_color, k % 4, k / 4);
            end
            checks++;
            if (write_page !== exp_wp || disp_page !== ~exp_wp) begin
                errors++;
                $display("FAIL clear_pages k=%0d got wp=%b dp=%b exp wp=%b", k, write_page, disp_page, exp_wp);
            end
            checks++;
            if (render_start !== exp_st || render_ack !== 1'b0) begin
                errors++;
                $display("FAIL clear_start k=%0d got start=%b ack=%b exp start=%b ack=0", k, render_start, render_ack, exp_st);
            end
        end
        @(negedge Clk);
        checks++;
        if (render_start !== 1'b0 || fb_we !== 1'b0) begin
            errors++;
            $display("FAIL start_single got start=%b we=%b exp 0 0", render_start, fb_we);
        end
        render_we = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; clear_en = 1'b1; new_frame = 1'b0; render_we = 1'b0; render_done = 1'b0;
        render_x = 9'd0; render_y = 8'd0; render_color = 8'h00;
        repeat (2) @(negedge Clk);
        checks++;
        if (fb_we !== 1'b0 || fb_x !== 9'd0 || fb_y !== 8'd0 || fb_color !== 8'h00) begin
            errors++;
            $display("FAIL reset_fb got we=%b x=%0d y=%0d c=%h exp 0", fb_we, fb_x, fb_y, fb_color);
        end
        checks++;
        if (disp_page !== 1'b0 || write_page !== 1'b1 || drop_count !== 8'd0 || render_start !== 1'b0 || render_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got dp=%b wp=%b drop=%0d st=%b ack=%b exp 0 1 0 0 0",
                     disp_page, write_page, drop_count, render_start, render_ack);
        end
        Reset = 1'b0;
        test_clear(1'b1);
    endtask

    task automatic test_passthrough();
        render_we = 1'b1; render_x = 9'd2; render_y = 8'd1; render_color = 8'h5A;
        @(negedge Clk);
        checks++;
        if (fb_we !== 1'b1 || fb_x !== 9'd2 || fb_y !== 8'd1 || fb_color !== 8'h5A) begin
            errors++;
            $display("FAIL pass_write got we=%b x=%0d y=%0d c=%h exp 1 2 1 5a", fb_we, fb_x, fb_y, fb_color);
        end
        render_x = 9'd4; render_y = 8'd0; render_color = 8'h11;
        @(negedge Clk);
        checks++;
        if (fb_we !== 1'b0) begin
            errors++;
            $display("FAIL pass_x_oob got we=%b exp 0", fb_we);
        end
        render_x = 9'd1; render_y = 8'd3;
        @(negedge Clk);
        checks++;
        if (fb_we !== 1'b0) begin
            errors++;
            $display("FAIL pass_y_oob got we=%b exp 0", fb_we);
        end
        render_we = 1'b0;
    endtask

    task automatic test_swap();
        render_done = 1'b1;
        @(negedge Clk);
        render_we = 1'b1; render_x = 9'd0; render_y = 8'd0;
        @(negedge Clk);
        checks++;
        if (fb_we !== 1'b0) begin
            errors++;
            $display("FAIL wait_discard got we=%b exp 0", fb_we);
        end
        render_we = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (disp_page !== 1'b0 || render_ack !== 1'b0) begin
            errors++;
            $display("FAIL pre_swap got dp=%b ack=%b exp 0 0", disp_page, render_ack);
        end
        new_frame = 1'b1;
        @(negedge Clk);
        new_frame = 1'b0; render_done = 1'b0;
        checks++;
        if (disp_page !== 1'b1 || write_page !== 1'b0 || render_ack !== 1'b1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL swap got dp=%b wp=%b ack=%b drop=%0d exp 1 0 1 0", disp_page, write_page, render_ack, drop_count);
        end
        test_clear(1'b0);
    endtask

    task automatic test_late_renderer();
        for (int i = 0; i < 3; i++) begin
            new_frame = 1'b1;
            @(negedge Clk);
            new_frame = 1'b0;
            @(negedge Clk);
        end
        checks++;
        if (drop_count !== 8'd3 || disp_page !== 1'b1) begin
            errors++;
            $display("FAIL late_drop got drop=%0d dp=%b exp 3 1", drop_count, disp_page);
        end
    endtask

    task automatic test_simultaneous();
        render_done = 1'b1; new_frame = 1'b1;
        @(negedge Clk);
        new_frame = 1'b0;
        checks++;
        if (drop_count !== 8'd4 || disp_page !== 1'b1 || render_ack !== 1'b0) begin
            errors++;
            $display("FAIL simul_drop got drop=%0d dp=%b ack=%b exp 4 1 0", drop_count, disp_page, render_ack);
        end
        repeat (2) @(negedge Clk);
        checks++;
        if (disp_page !== 1'b1 || render_ack !== 1'b0) begin
            errors++;
            $display("FAIL simul_hold got dp=%b ack=%b exp 1 0", disp_page, render_ack);
        end
        new_frame = 1'b1;
        @(negedge Clk);
        new_frame = 1'b0; render_done = 1'b0;
        checks++;
        if (disp_page !== 1'b0 || write_page !== 1'b1 || render_ack !== 1'b1 || drop_count !== 8'd4) begin
            errors++;
            $display("FAIL simul_swap got dp=%b wp=%b ack=%b drop=%0d exp 0 1 1 4", disp_page, write_page, render_ack, drop_count);
        end
        test_clear(1'b1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            new_frame = 1'b1;
            @(negedge Clk);
            new_frame = 1'b0;
            @(negedge Clk);
        end
        checks++;
        if (drop_count !== 8'd255 || disp_page !== 1'b0) begin
            errors++;
            $display("FAIL saturate got drop=%0d dp=%b exp 255 0", drop_count, disp_page);
        end
    endtask

    task automatic test_reset_mid_clear_noclear();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        checks++;
        if (fb_we !== 1'b1 || fb_x !== 9'd1 || fb_y !== 8'd1) begin
            errors++;
            $display("FAIL mid_clear_pos got we=%b x=%0d y=%0d exp 1 1 1", fb_we, fb_x, fb_y);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (fb_we !== 1'b0 || fb_x !== 9'd0 || fb_y !== 8'd0 || fb_color !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_fb got we=%b x=%0d y=%0d c=%h exp 0", fb_we, fb_x, fb_y, fb_color);
        end
        checks++;
        if (drop_count !== 8'd0 || disp_page !== 1'b0 || write_page !== 1'b1 || render_start !== 1'b0 || render_ack !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl got drop=%0d dp=%b wp=%b st=%b ack=%b exp 0 0 1 0 0",
                     drop_count, disp_page, write_page, render_start, render_ack);
        end
        clear_en = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (render_start !== 1'b1 || fb_we !== 1'b0) begin
            errors++;
            $display("FAIL noclear_start got st=%b we=%b exp 1 0", render_start, fb_we);
        end
        @(negedge Clk);
        checks++;
        if (render_start !== 1'b0 || fb_we !== 1'b0) begin
            errors++;
            $display("FAIL noclear_after got st=%b we=%b exp 0 0", render_start, fb_we);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_swap();
        test_late_renderer();
        test_simultaneous();
        test_saturate();
        test_reset_mid_clear_noclear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
